// File: rtl/cache_set_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cache_set_ctrl                                               |
// | Description : Per-set controller for one 4-way cache set. Accepts CPU      |
// |               read/write requests, resolves hit/miss against the lines,    |
// |               picks an LRU victim, performs dirty write-back and fill over |
// |               a memory handshake, strobes the lines and returns a response.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst            clock (rising edge), asynchronous active-high reset  |
// |   req_*               CPU request channel (valid/ready, write, addr, wdata) |
// |   resp_*              one-cycle response pulse with hit flag and read data |
// |   way_hit/valid/dirty per-way status bits from the lines                   |
// |   way_age/tag/data    per-way packed age (2b), tag and data byte           |
// |   line_*              shared ready/address/write data to all lines         |
// |   way_try_read/write  one-hot access strobes (UPDATE only)                 |
// |   way_reset_age       one-hot age reset (UPDATE only)                      |
// |   way_increment_age   age bump for younger valid ways (UPDATE only)        |
// |   mem_*               memory request/ack handshake for write-back and fill |
// +----------------------------------------------------------------------------+

module cache_set_ctrl #(
  parameter int ADDRESS_WORD_SIZE = 32,
  parameter int TAG_SIZE          = 19,
  parameter int NUM_WAYS          = 4    // only 4 is supported (2-bit ages)
) (
  input  logic                           clk,
  input  logic                           rst,
  // CPU request / response
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDRESS_WORD_SIZE-1:0]   req_addr,
  input  logic [7:0]                     req_wdata,
  output logic                           resp_valid,
  output logic                           resp_hit,
  output logic [7:0]                     resp_rdata,
  // Line status
  input  logic [NUM_WAYS-1:0]            way_hit,
  input  logic [NUM_WAYS-1:0]            way_valid,
  input  logic [NUM_WAYS-1:0]            way_dirty,
  input  logic [2*NUM_WAYS-1:0]          way_age,
  input  logic [TAG_SIZE*NUM_WAYS-1:0]   way_tag,
  input  logic [8*NUM_WAYS-1:0]          way_data,
  // Line control
  output logic                           line_ready,
  output logic [ADDRESS_WORD_SIZE-1:0]   line_address,
  output logic [7:0]                     line_wdata,
  output logic [NUM_WAYS-1:0]            way_try_read,
  output logic [NUM_WAYS-1:0]            way_try_write,
  output logic [NUM_WAYS-1:0]            way_reset_age,
  output logic [NUM_WAYS-1:0]            way_increment_age,
  // Memory handshake
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDRESS_WORD_SIZE-1:0]   mem_addr,
  output logic [7:0]                     mem_wdata,
  input  logic                           mem_ack,
  input  logic [7:0]                     mem_rdata
);

  localparam int OFFSET_W = ADDRESS_WORD_SIZE - TAG_SIZE;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOOKUP  = 3'd1,
    S_EVICT   = 3'd2,
    S_FILL    = 3'd3,
    S_UPDATE  = 3'd4,
    S_RESPOND = 3'd5
  } state_t;

  state_t state, state_next;

  // Latched request and lookup results
  logic [ADDRESS_WORD_SIZE-1:0] addr_q;
  logic                         write_q;
  logic [7:0]                   wdata_q;
  logic                         hit_q;
  logic [1:0]                   target_q;
  logic [1:0]                   old_age_q;
  logic [7:0]                   rdata_q;
  logic [ADDRESS_WORD_SIZE-1:0] evict_addr_q;
  logic [7:0]                   evict_data_q;

  // Lookup decode
  logic                hit_any;
  logic [1:0]          hit_idx;
  logic                inv_any;
  logic [1:0]          inv_idx;
  logic [1:0]          max_idx;
  logic [1:0]          max_age;
  logic [1:0]          victim_idx;
  logic [1:0]          sel_idx;
  logic [1:0]          sel_age;
  logic                sel_valid;
  logic [7:0]          hit_data;
  logic                victim_valid;
  logic                victim_dirty;
  logic [TAG_SIZE-1:0] victim_tag;
  logic [7:0]          victim_data;
  logic [NUM_WAYS-1:0] target_onehot;

  // Hit way, lowest invalid way and oldest way (ties keep the lowest index).
  always_comb begin
    hit_any = |way_hit;
    inv_any = ~&way_valid;
    hit_idx = 2'd0;
    inv_idx = 2'd0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_hit[i])    hit_idx = 2'(i);
      if (!way_valid[i]) inv_idx = 2'(i);
    end
    max_idx = 2'd0;
    max_age = way_age[1:0];
    for (int i = 1; i < NUM_WAYS; i++) begin
      if (way_age[2*i +: 2] > max_age) begin
        max_age = way_age[2*i +: 2];
        max_idx = 2'(i);
      end
    end
    victim_idx = inv_any ? inv_idx : max_idx;
    sel_idx    = hit_any ? hit_idx : victim_idx;
  end

  // Per-way field muxes for the selected target and the victim.
  always_comb begin
    sel_age      = 2'd0;
    sel_valid    = 1'b0;
    hit_data     = 8'd0;
    victim_valid = 1'b0;
    victim_dirty = 1'b0;
    victim_tag   = '0;
    victim_data  = 8'd0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (2'(i) == sel_idx) begin
        sel_age   = way_age[2*i +: 2];
        sel_valid = way_valid[i];
      end
      if (2'(i) == hit_idx) begin
        hit_data = way_data[8*i +: 8];
      end
      if (2'(i) == victim_idx) begin
        victim_valid = way_valid[i];
        victim_dirty = way_dirty[i];
        victim_tag   = way_tag[TAG_SIZE*i +: TAG_SIZE];
        victim_data  = way_data[8*i +: 8];
      end
    end
  end

  assign target_onehot = NUM_WAYS'(1) << target_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= 8'd0;
      hit_q        <= 1'b0;
      target_q     <= 2'd0;
      old_age_q    <= 2'd0;
      rdata_q      <= 8'd0;
      evict_addr_q <= '0;
      evict_data_q <= 8'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            write_q <= req_write;
            wdata_q <= req_wdata;
          end
        end
        S_LOOKUP: begin
          hit_q     <= hit_any;
          target_q  <= sel_idx;
          // An invalid target counts as oldest so all valid ways age.
          old_age_q <= sel_valid ? sel_age : 2'd3;
          // Writes always answer 0; read misses overwrite this during FILL.
          rdata_q   <= (hit_any && !write_q) ? hit_data : 8'd0;
          evict_addr_q <= {victim_tag, addr_q[OFFSET_W-1:0]};
          evict_data_q <= victim_data;
        end
        S_FILL: begin
          if (mem_ack && !write_q) begin
            rdata_q <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and outputs
  always_comb begin
    state_next        = state;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    resp_hit          = 1'b0;
    resp_rdata        = 8'd0;
    line_ready        = 1'b0;
    way_try_read      = '0;
    way_try_write     = '0;
    way_reset_age     = '0;
    way_increment_age = '0;
    mem_req           = 1'b0;
    mem_we            = 1'b0;
    mem_addr          = '0;
    mem_wdata         = 8'd0;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (hit_any)                          state_next = S_UPDATE;
        else if (victim_valid && victim_dirty) state_next = S_EVICT;
        else                                  state_next = S_FILL;
      end
      S_EVICT: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = evict_addr_q;
        mem_wdata = evict_data_q;
        if (mem_ack) state_next = S_FILL;
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) state_next = S_UPDATE;
      end
      S_UPDATE: begin
        line_ready    = 1'b1;
        way_try_read  = write_q ? '0 : target_onehot;
        way_try_write = write_q ? target_onehot : '0;
        way_reset_age = target_onehot;
        for (int i = 0; i < NUM_WAYS; i++) begin
          way_increment_age[i] = way_valid[i] && (2'(i) != target_q) &&
                                 (way_age[2*i +: 2] < old_age_q);
        end
        state_next = S_RESPOND;
      end
      S_RESPOND: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        resp_rdata = rdata_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign line_address = addr_q;
  assign line_wdata   = wdata_q;

endmodule

`default_nettype wire
